wb_host_master: RTL and testbench
=================================

# wb_host_master

Wishbone classic (B4, non-pipelined) single-transfer master that turns a valid/ready command stream into one bus cycle per command and returns a valid/ready response. It is the initiator counterpart to our Wishbone slave user-project wrapper. It drives the management-side test bench, and any on-chip agent that needs to reach user-area registers over Wishbone. It adds a bus-cycle timeout so a non-responding slave cannot hang the initiator.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `TIMEOUT`, 255, maximum wait cycles per bus cycle; 0 disables timeout

Ports:
- `wb_clk_i`  in  1  clock; all logic on its rising edge
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i & cmd_ready_o`
- `cmd_we_i`  in  1  1 = write, 0 = read
- `cmd_adr_i`  in  AW  byte address
- `cmd_dat_i`  in  DW  write data
- `cmd_sel_i`  in  DW/8  byte selects
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed when `rsp_valid_o & rsp_ready_i`
- `rsp_dat_o`  out  DW  read data; 0 for writes and errors
- `rsp_err_o`  out  1  1 = slave `err` or timeout
- `rsp_tmo_o`  out  1  1 = timeout (implies `rsp_err_o`)
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  Wishbone control
- `wbm_adr_o`  out  AW  Wishbone address
- `wbm_dat_o`  out  DW  Wishbone write data
- `wbm_sel_o`  out  DW/8  Wishbone byte selects
- `wbm_ack_i`, `wbm_err_i`  in  1  slave termination
- `wbm_dat_i`  in  DW  slave read data

## Operation
- **FSM states:** IDLE, BUS, RESP.
- **IDLE:**
  - `cmd_ready_o` = 1.
  - On accept: register `we/adr/dat/sel` onto the `wbm_*` outputs, clear the wait counter, go to BUS.
- **BUS:**
  - `wbm_cyc_o` = `wbm_stb_o` = 1.
  - All `wbm_*` outputs stay stable until termination.
  - `wbm_err_i` = 1: capture `err`=1, `tmo`=0, `dat`=0; go to RESP.
  - `wbm_ack_i` = 1 and `wbm_err_i` = 0: capture `err`=0, `tmo`=0, and `dat` = `wbm_dat_i` for reads or 0 for writes; go to RESP.
  - `ack` and `err` asserted together: `err` wins.
  - No termination: increment the wait counter, which is `$clog2(TIMEOUT+1)` bits wide and saturates. When the counter equals `TIMEOUT` (and `TIMEOUT` ≠ 0) with no termination on that edge: capture `err`=1, `tmo`=1, `dat`=0; go to RESP.
- **RESP:**
  - `wbm_cyc_o` = `wbm_stb_o` = 0.
  - `rsp_valid_o` = 1; `rsp_*` are held stable until handshake.
  - On `rsp_ready_i`: go to IDLE.
- **Ordering:** one outstanding command only. `cmd_ready_o` = 0 in BUS and RESP.
- **Late terminations:** `wbm_ack_i` / `wbm_err_i` seen outside BUS are ignored.
- **Reset:**
  - Asserting `wb_rst_ni` at any time (including mid-BUS) forces IDLE immediately. This drops `cyc`/`stb` without waiting for a clock.
  - Reset values: `cmd_ready_o`=1 (IDLE); `rsp_valid_o`, `rsp_err_o`, `rsp_tmo_o`, `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0; `rsp_dat_o`, `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o` = 0.

## Timing
- Command accepted at edge N. `cyc`/`stb` are high from after edge N.
- Termination sampled at edge N+k (k ≥ 1; k = 1 for a zero-wait slave):
  - `cyc`/`stb` low after edge N+k;
  - `rsp_valid_o` high in the same cycle.
- Minimum command-to-response latency: 2 cycles.
- Minimum accept-to-next-accept: 3 cycles (accept, BUS, RESP with `rsp_ready_i`=1, then IDLE).
- `cyc` deasserts for at least one cycle between consecutive bus cycles.
- Timeout: with no termination, the response appears after edge N+`TIMEOUT`. `stb` is high for exactly `TIMEOUT` cycles.
- All outputs are registered or decoded from FSM state only; there are no combinational paths from inputs to outputs.

## Test plan
- **Zero-wait write:** write `adr`=0x3000_0004, `dat`=0xDEAD_BEEF, `sel`=0xF; slave acks in the first BUS cycle.
  - Bus shows those values with `we`=1 for exactly 1 cycle.
  - Response 2 cycles after accept: `err`=0, `dat`=0.
- **Read with 3 wait states:** read 0x3000_0010; slave returns 0x1234_5678 with `ack` on the 4th BUS cycle.
  - `stb` high for 4 cycles with outputs stable.
  - Response: `rsp_dat_o`=0x1234_5678, `err`=0.
- **Timeout:** `TIMEOUT`=8, slave silent.
  - `stb` high for exactly 8 cycles, then `rsp_err_o`=1, `rsp_tmo_o`=1, `dat`=0.
  - A `wbm_ack_i` pulse driven during RESP is ignored.
- **Error wins:** slave asserts `ack` and `err` together on a read.
  - Response: `err`=1, `tmo`=0, `dat`=0.
- **Response backpressure:** hold `rsp_ready_i`=0 for 5 cycles after `rsp_valid_o`.
  - Response stays stable; `cmd_ready_o`=0 throughout; `cyc`=0.
  - After the handshake, `cmd_ready_o`=1 the next cycle.
- **Async reset mid-cycle:** drive `wb_rst_ni` low between clock edges during BUS.
  - `wbm_cyc_o`/`wbm_stb_o` drop before the next edge, with all outputs at reset values.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master: one bus cycle per valid/ready command,
// one valid/ready response per bus cycle, with a per-cycle wait timeout.
module wb_host_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            rsp_tmo_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  // state | meaning
  // IDLE  | ready for a command, bus idle
  // BUS   | cyc/stb asserted, waiting for ack/err or timeout
  // RESP  | response held until rsp_ready_i
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;

  // Timeout fires on the edge where the saturating count reaches TIMEOUT,
  // so stb is high for exactly TIMEOUT cycles.
  assign wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + CW'(1);

  assign cmd_ready_o = (state == IDLE);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);
  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
      rsp_tmo_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wait_cnt  <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_err_i) begin
            rsp_err_o <= 1'b1;
            rsp_tmo_o <= 1'b0;
            rsp_dat_o <= '0;
            state     <= RESP;
          end else if (wbm_ack_i) begin
            rsp_err_o <= 1'b0;
            rsp_tmo_o <= 1'b0;
            rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
            state     <= RESP;
          end else if ((TIMEOUT != 0) && (wait_nxt == TMO_CNT)) begin
            rsp_err_o <= 1'b1;
            rsp_tmo_o <= 1'b1;
            rsp_dat_o <= '0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: directed scenarios plus random transactions against
// a transaction-level model of the expected bus/response behaviour.
module tb_wb_host_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          rsp_tmo;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [AW-1:0] wbm_adr;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel;
  logic          wbm_ack = 1'b0;
  logic          wbm_err = 1'b0;
  logic [DW-1:0] wbm_dat_i = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_host_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .rsp_tmo_o  (rsp_tmo),
    .wbm_cyc_o  (wbm_cyc),
    .wbm_stb_o  (wbm_stb),
    .wbm_we_o   (wbm_we),
    .wbm_adr_o  (wbm_adr),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel),
    .wbm_ack_i  (wbm_ack),
    .wbm_err_i  (wbm_err),
    .wbm_dat_i  (wbm_dat_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // term: 0 = ack, 1 = err, 2 = ack+err, 3 = silent slave.
  // wait_n: number of BUS cycles before the slave terminates.
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input int wait_n, input int term,
                         input logic [DW-1:0] rdata, input int bp);
    int            exp_stb;
    logic          exp_err, exp_tmo;
    logic [DW-1:0] exp_dat;
    int            stb_cnt;
    bit            done;
    if (term != 3 && wait_n < TMO) begin
      exp_stb = wait_n + 1;
      exp_err = (term != 0);
      exp_tmo = 1'b0;
      exp_dat = (term == 0 && !we) ? rdata : '0;
    end else begin
      exp_stb = TMO;
      exp_err = 1'b1;
      exp_tmo = 1'b1;
      exp_dat = '0;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = SW'($urandom);
    stb_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < TMO + 4 && !done; c++) begin
      check("bus_cyc", wbm_cyc, 1);
      check("bus_stb", wbm_stb, 1);
      check("bus_we", wbm_we, we);
      check("bus_adr", wbm_adr, adr);
      check("bus_dat", wbm_dat_o, dat);
      check("bus_sel", wbm_sel, sel);
      check("bus_cmd_ready", cmd_ready, 0);
      stb_cnt++;
      if (term != 3 && c == wait_n) begin
        wbm_ack = (term != 1);
        wbm_err = (term != 0);
        wbm_dat_i = rdata;
      end else begin
        wbm_dat_i = $urandom;
      end
      tick();
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      done = rsp_valid;
    end
    check("bus_done", done, 1);
    check("stb_cycles", stb_cnt, exp_stb);
    check("resp_cyc", wbm_cyc, 0);
    check("resp_stb", wbm_stb, 0);
    for (int b = 0; b <= bp; b++) begin
      rsp_ready = (b == bp);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_dat", rsp_dat, exp_dat);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_tmo", rsp_tmo, exp_tmo);
      check("rsp_cmd_ready", cmd_ready, 0);
      check("rsp_cyc", wbm_cyc, 0);
      wbm_ack = 1'($urandom);
      wbm_err = 1'($urandom);
      tick();
    end
    rsp_ready = 1'b0;
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_cyc", wbm_cyc, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_tmo"}, rsp_tmo, 0);
    check({tag, "_rsp_dat"}, rsp_dat, 0);
    check({tag, "_cyc"}, wbm_cyc, 0);
    check({tag, "_stb"}, wbm_stb, 0);
    check({tag, "_we"}, wbm_we, 0);
    check({tag, "_adr"}, wbm_adr, 0);
    check({tag, "_dat"}, wbm_dat_o, 0);
    check({tag, "_sel"}, wbm_sel, 0);
  endtask

  initial begin
    #2;
    check_reset_values("rst");
    #10 rst_n = 1'b1;
    tick();

    // zero-wait write
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0BAD_0BAD, 0);
    // read with 3 wait states
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 0, 32'h1234_5678, 0);
    // silent slave: timeout, late acks pulsed during RESP
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 3, 32'h0, 2);
    // ack and err together on a read
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 0);
    // ack on the last cycle before timeout
    run_txn(1'b0, 32'h3000_0040, 32'h0, 4'h3, TMO - 1, 0, 32'hA5A5_5A5A, 0);
    // response backpressure
    run_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, 2, 0, 32'h0F0F_1234, 5);

    // async reset in the middle of a bus cycle
    cmd_valid = 1'b1;
    cmd_we = 1'b1; cmd_adr = 32'h3000_0060; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_cyc", wbm_cyc, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    #3 rst_n = 1'b1;
    tick();
    run_txn(1'b0, 32'h3000_0070, 32'h0, 4'hF, 1, 0, 32'h7777_0001, 0);

    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, SW'($urandom),
              int'($urandom_range(0, TMO + 2)), int'($urandom_range(0, 3)),
              $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
